digits_to_binary: RTL and testbench
===================================

Name: digits_to_binary

Overview:
Converts a three-digit decimal value (hundreds, tens, ones) into a clamped binary level. It is the inverse of the binary-to-digits display path. It sits between the digit-entry front end and the PWM duty register. Conversion is multi-cycle: one digit is processed per clock, MSD first, with valid/ready handshakes on both sides.

Parameters:
OUT_W, 4, width of binary_out; MAX_VALUE must be < 2**OUT_W
MAX_VALUE, 10, saturation ceiling for the result (PWM duty levels 0..10)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  digit triple presented
in_ready  output  1  block can accept a triple
digit0  input  4  ones digit, BCD
digit1  input  4  tens digit, BCD
digit2  input  4  hundreds digit, BCD
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
binary_out  output  OUT_W  converted, clamped value
overflow  output  1  true value exceeded MAX_VALUE; result clamped
digit_err  output  1  at least one input digit was > 9

Behaviour:
- Design has one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-conversion):
  - state returns to IDLE; the in-flight conversion is discarded and no out_valid is produced.
  - binary_out = 0, overflow = 0, digit_err = 0, out_valid = 0, internal accumulator = 0.
  - in_ready = 1 from the first cycle after reset release.
- State machine:
  - IDLE: in_ready = 1. On in_valid && in_ready at edge N:
    - latch the three digits;
    - set err_q = (any digit > 9);
    - acc <= 0, digit index <= 2;
    - go to CONV.
  - CONV: in_ready = 0, in_valid ignored. Each edge: acc <= acc*10 + latched digit[index], with index stepping 2, then 1, then 0. After the index-0 step, go to HOLD.
  - HOLD: out_valid = 1.
    - Outputs are loaded on entry and held stable until out_valid && out_ready.
    - At that handshake edge, clear out_valid and return to IDLE.
    - in_ready rises on the following cycle; no same-cycle accept of a new triple.
- Latency: accept at edge N, out_valid high after edge N+3. Minimum throughput is one triple per 5 cycles with out_ready tied high.
- Output rules, computed when entering HOLD:
  - If err_q: binary_out = 0, digit_err = 1, overflow = 0.
  - Else if acc > MAX_VALUE: binary_out = MAX_VALUE, overflow = 1.
  - Else: binary_out = acc[OUT_W-1:0], overflow = 0.
- Arithmetic:
  - acc is ACC_W = 11 bits unsigned, enough for 15*111 = 1665, so invalid digits never wrap.
  - Multiply-by-10 is implemented as (acc<<3) + (acc<<1), plus the zero-extended digit. No DSP inference.
- All outputs are registered. in_ready is decoded directly from the state register (no input paths).
- Leading zeros are legal; 0,0,0 converts to 0.
- out_ready asserted while not in HOLD has no effect.

Decomposition:
- Shared package d2b_pkg:
  - state enum IDLE/CONV/HOLD;
  - NUM_DIGITS = 3, DIGIT_W = 4, DIGIT_MAX = 9, ACC_W = 11.
- One sub-module is natural: digit_mac10. It is combinational, computes acc*10 + digit at ACC_W width, and is reused by any future wider-digit variant.
- FSM, digit mux, clamp and handshake logic stay in digits_to_binary.

Test Plan:
1. Round trip: for v = 0..10, drive the binary_to_digits outputs of v with in_valid=1 and out_ready=1 -> binary_out = v, overflow = 0, digit_err = 0, out_valid exactly 3 cycles after accept.
2. Clamp: 0,1,1 -> binary_out = 10, overflow = 1. Also 9,9,9 -> binary_out = 10, overflow = 1, digit_err = 0.
3. Invalid digit: digit2=0, digit1=0, digit0=12 -> binary_out = 0, digit_err = 1, overflow = 0. Also digit2=15, others 0 -> same response.
4. Backpressure: 0,0,7 with out_ready = 0 for 5 cycles -> out_valid and binary_out = 7 held stable, in_ready = 0, a new in_valid is ignored. Raise out_ready -> out_valid drops next cycle, in_ready = 1 the cycle after.
5. Reset mid-operation: accept 0,1,0, then pulse rst_n low (asynchronously, between edges) during CONV -> all outputs 0 immediately, no out_valid afterwards. After release, 0,0,3 converts to 3.
6. Back-to-back: hold in_valid high with a stream of triples and out_ready = 1 -> each result appears once, in order, with exactly a 5-cycle spacing between accepts.

Source files
------------

// File: rtl/d2b_pkg.sv
// Shared types and sizing for the decimal-digit to binary converter.
package d2b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 4;
    localparam int DIGIT_MAX  = 9;
    // 15*111 = 1665 fits, so illegal digits never wrap the accumulator
    localparam int ACC_W      = 11;

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/digit_mac10.sv
// Combinational acc*10 + digit at accumulator width, built from shifts and adds.
module digit_mac10
    import d2b_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [ACC_W-1:0]   result
);

    assign result = (acc << 3) + (acc << 1) + {{(ACC_W-DIGIT_W){1'b0}}, digit};

endmodule

// File: rtl/digits_to_binary.sv
// Three BCD digits to a clamped binary level, one digit per clock MSD first.
// Result valid three edges after accept and held until the consumer takes it.
module digits_to_binary
    import d2b_pkg::*;
#(
    parameter int OUT_W     = 4,
    parameter int MAX_VALUE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       digit0,
    input  logic [3:0]       digit1,
    input  logic [3:0]       digit2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] binary_out,
    output logic             overflow,
    output logic             digit_err
);

    state_t               state;
    state_t               state_nxt;
    logic [DIGIT_W-1:0]   dig_q [NUM_DIGITS];
    logic [1:0]           idx;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     mac_out;
    logic [DIGIT_W-1:0]   cur_digit;
    logic                 err_q;
    logic                 accept;
    logic                 last_step;
    logic                 done;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state == CONV) && (idx == 2'd0);
    assign done      = (state == HOLD) && out_ready;

    always_comb begin
        cur_digit = '0;
        case (idx)
            2'd0:    cur_digit = dig_q[0];
            2'd1:    cur_digit = dig_q[1];
            2'd2:    cur_digit = dig_q[2];
            default: cur_digit = '0;
        endcase
    end

    digit_mac10 u_mac (
        .acc    (acc),
        .digit  (cur_digit),
        .result (mac_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CONV;
            CONV:    if (last_step) state_nxt = HOLD;
            HOLD:    if (done)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
            idx        <= '0;
            acc        <= '0;
            err_q      <= 1'b0;
            out_valid  <= 1'b0;
            binary_out <= '0;
            overflow   <= 1'b0;
            digit_err  <= 1'b0;
        end else begin
            if (accept) begin
                dig_q[0] <= digit0;
                dig_q[1] <= digit1;
                dig_q[2] <= digit2;
                err_q    <= digit_bad(digit0) || digit_bad(digit1) || digit_bad(digit2);
                acc      <= '0;
                idx      <= 2'd2;
            end else if (state == CONV) begin
                acc <= mac_out;
                if (idx != 2'd0) idx <= idx - 2'd1;
            end

            // Outputs load from the final MAC result, not the stale acc register
            if (last_step) begin
                out_valid <= 1'b1;
                if (err_q) begin
                    binary_out <= '0;
                    overflow   <= 1'b0;
                    digit_err  <= 1'b1;
                end else if (mac_out > ACC_W'(MAX_VALUE)) begin
                    binary_out <= OUT_W'(MAX_VALUE);
                    overflow   <= 1'b1;
                    digit_err  <= 1'b0;
                end else begin
                    binary_out <= mac_out[OUT_W-1:0];
                    overflow   <= 1'b0;
                    digit_err  <= 1'b0;
                end
            end else if (done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digits_to_binary.sv
// Randomized and directed checks of digits_to_binary against a cycle-level reference model.
module tb_digits_to_binary;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] digit0 = '0;
    logic [3:0] digit1 = '0;
    logic [3:0] digit2 = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] binary_out;
    logic       overflow;
    logic       digit_err;

    digits_to_binary #(.OUT_W(4), .MAX_VALUE(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .overflow   (overflow),
        .digit_err  (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] out;
        logic       ovf;
        logic       err;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rnd_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t ref_conv(input int d2, input int d1, input int d0);
        res_t r;
        int   v;
        v = d2 * 100 + d1 * 10 + d0;
        r = '0;
        if (d2 > 9 || d1 > 9 || d0 > 9) r.err = 1'b1;
        else if (v > 10) begin r.out = 4'd10; r.ovf = 1'b1; end
        else r.out = 4'(v);
        return r;
    endfunction

    // Reference: idle -> (accept) three conversion cycles -> hold until taken
    int   m_phase = 0;
    int   m_cnt = 0;
    bit   m_valid = 1'b0;
    res_t m_pend = '0;
    res_t m_res = '0;
    res_t sb[$];

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_valid = 1'b0;
            m_res   = '0;
            sb.delete();
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  = ref_conv(int'(digit2), int'(digit1), int'(digit0));
                    sb.push_back(m_pend);
                    m_cnt   = 3;
                    m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                        m_res   = m_pend;
                    end
                end
                default: if (out_ready) begin
                    m_valid = 1'b0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("in_ready", int'(in_ready), int'(m_phase == 0));
            if (m_valid) begin
                chk("binary_out", int'(binary_out), int'(m_res.out));
                chk("overflow", int'(overflow), int'(m_res.ovf));
                chk("digit_err", int'(digit_err), int'(m_res.err));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_result", 1, 0);
                else begin
                    res_t e;
                    e = sb.pop_front();
                    chk("sb_result", int'({binary_out, overflow, digit_err}), int'(e));
                end
            end
        end
    end

    task automatic send(input int d2, input int d1, input int d0, input bit keep,
                        output int acc_cyc);
        bit rdy;
        bit ok;
        digit2   = 4'(d2);
        digit1   = 4'(d1);
        digit0   = 4'(d0);
        in_valid = 1'b1;
        ok       = 1'b0;
        acc_cyc  = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int eo, input int eovf, input int eerr,
                            input int elat);
        bit ok;
        ok = 1'b0;
        for (int n = 1; n <= 30 && !ok; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                if (elat > 0) chk({nm, "_latency"}, n, elat);
                chk({nm, "_value"}, int'(binary_out), eo);
                chk({nm, "_overflow"}, int'(overflow), eovf);
                chk({nm, "_digit_err"}, int'(digit_err), eerr);
            end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ac;
        int prev;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_binary_out", int'(binary_out), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_digit_err", int'(digit_err), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_in_ready", int'(in_ready), 1);

        // round trip 0..10
        for (int v = 0; v <= 10; v++) begin
            send(v / 100, (v / 10) % 10, v % 10, 1'b0, ac);
            wait_out("roundtrip", v, 0, 0, 4);
        end

        send(0, 1, 1, 1'b0, ac);  wait_out("clamp_011", 10, 1, 0, 4);
        send(9, 9, 9, 1'b0, ac);  wait_out("clamp_999", 10, 1, 0, 4);
        send(0, 0, 12, 1'b0, ac); wait_out("bad_d0", 0, 0, 1, 4);
        send(15, 0, 0, 1'b0, ac); wait_out("bad_d2", 0, 0, 1, 4);

        // backpressure: result held, new triple refused while holding
        out_ready = 1'b0;
        send(0, 0, 7, 1'b0, ac);
        repeat (3) @(posedge clk);
        #1;
        digit0 = 4'd5; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_value", int'(binary_out), 7);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_drop_valid", int'(out_valid), 0);
        chk("bp_in_ready_after", int'(in_ready), 1);

        // reset mid-conversion
        send(0, 1, 0, 1'b0, ac);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_binary_out", int'(binary_out), 0);
        chk("arst_overflow", int'(overflow), 0);
        chk("arst_digit_err", int'(digit_err), 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_no_valid", int'(out_valid), 0);
        end
        send(0, 0, 3, 1'b0, ac);
        wait_out("after_rst", 3, 0, 0, 4);

        // back-to-back with in_valid held high
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 9)), 1'b1, ac);
            if (prev >= 0) chk("b2b_spacing", ac - prev, 5);
            prev = ac;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // random traffic with random consumer stalls
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1 if (rnd_on) out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int k = 0; k < 40; k++) begin
            int d2;
            d2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            send(d2, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, ac);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
